// File: rtl/fifo_tg_pkg.sv
// Shared definitions for the FIFO traffic generator: pattern modes, FSM states,
// drain length and Galois LFSR tap masks per supported data width.
package fifo_tg_pkg;

    localparam logic [1:0] MODE_INCR = 2'd0;
    localparam logic [1:0] MODE_LFSR = 2'd1;
    localparam logic [1:0] MODE_WALK = 2'd2;
    localparam logic [1:0] MODE_ALT  = 2'd3;

    localparam int DRAIN_CYCLES = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_INIT = 3'd1,
        ST_WRITE     = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_READ      = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Right-shifting Galois masks of maximal-length polynomials
    function automatic logic [63:0] lfsr_taps(input int unsigned width);
        logic [63:0] taps;
        case (width)
            32'd8:   taps = 64'h0000_0000_0000_00B8;
            32'd16:  taps = 64'h0000_0000_0000_B400;
            32'd32:  taps = 64'h0000_0000_8020_0003;
            32'd64:  taps = 64'hD800_0000_0000_0000;
            default: taps = 64'h0000_0000_0000_00B8;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/fifo_tg_pattern.sv
// One data-pattern generator: loads its start value with a mode, then advances
// once per accepted word. Used for both the write stream and the expected stream.
module fifo_tg_pattern
    import fifo_tg_pkg::*;
#(
    parameter int                DATA_W = 32,
    parameter logic [DATA_W-1:0] SEED   = {{(DATA_W-1){1'b0}}, 1'b1}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [1:0]        load_mode,
    input  logic              advance,
    output logic [DATA_W-1:0] value
);

    localparam logic [63:0]       TAPS_FULL = lfsr_taps(DATA_W);
    localparam logic [DATA_W-1:0] TAPS      = TAPS_FULL[DATA_W-1:0];
    localparam logic [DATA_W-1:0] ONE       = {{(DATA_W-1){1'b0}}, 1'b1};

    logic [1:0]        mode_r;
    logic [DATA_W-1:0] value_r;
    logic [DATA_W-1:0] value_next_s;

    // successor of the current value under the latched pattern
    always_comb begin
        value_next_s = value_r;
        case (mode_r)
            MODE_INCR: value_next_s = value_r + ONE;
            MODE_LFSR: value_next_s = value_r[0] ? ((value_r >> 1) ^ TAPS) : (value_r >> 1);
            MODE_WALK: value_next_s = {value_r[DATA_W-2:0], value_r[DATA_W-1]};
            MODE_ALT:  value_next_s = ~value_r;
            default:   value_next_s = value_r;
        endcase
    end

    // generator state; walking-one always restarts from bit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r  <= MODE_INCR;
            value_r <= SEED;
        end else if (load) begin
            mode_r  <= load_mode;
            value_r <= (load_mode == MODE_WALK) ? ONE : SEED;
        end else if (advance) begin
            value_r <= value_next_s;
        end else begin
            value_r <= value_r;
        end
    end

    assign value = value_r;

endmodule

// File: rtl/fifo_traffic_gen.sv
// Write-then-readback traffic generator/checker for the DDR2-backed FIFO.
// Optional FIFO_TG_ERR_CAPTURE_EN adds first-mismatch capture outputs.
module fifo_traffic_gen
    import fifo_tg_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                BURST_LEN = 1024,
    parameter int                CNT_W     = 16,
    parameter logic [DATA_W-1:0] SEED      = {{(DATA_W-1){1'b0}}, 1'b1},
    parameter int                TIMEOUT   = 4096
) (
    input  logic              sys_clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              phy_init_done,
    input  logic              full,
    input  logic              empty,
    input  logic              dout_vd,
    input  logic [DATA_W-1:0] data_out,
    output logic              wr_en,
    output logic [DATA_W-1:0] data_in,
    output logic              rd_en,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  err_cnt
`ifdef FIFO_TG_ERR_CAPTURE_EN
    ,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_exp,
    output logic [DATA_W-1:0] first_err_act,
    output logic              err_seen
`endif
);

    localparam int               WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] BURST      = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [WD_W-1:0]  WD_ZERO    = {WD_W{1'b0}};
    localparam logic [WD_W-1:0]  WD_ONE     = {{(WD_W-1){1'b0}}, 1'b1};
    localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam logic [2:0]       DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_t            state_r, state_next_s;
    logic [CNT_W-1:0]  wr_cnt_r, wr_cnt_next_s, rd_cnt_r, rd_cnt_next_s;
    logic [CNT_W-1:0]  err_cnt_r, err_cnt_next_s, rd_issued_r, rd_issued_next_s;
    logic [WD_W-1:0]   wd_r, wd_next_s;
    logic [2:0]        drain_r, drain_next_s;
    logic              wr_en_r, wr_en_next_s, timeout_r, timeout_next_s;
    logic              busy_r, busy_next_s, done_r, done_next_s, pass_r, pass_next_s;
    logic              start_ok_s, active_s, rd_en_s, rd_seen_s, rd_take_s;
    logic              mismatch_s, wd_fire_s, err_bump_s;
    logic [DATA_W-1:0] wr_value_s, exp_value_s;

    // next state, run counters, watchdog and status
    always_comb begin
        start_ok_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        active_s   = (state_r == ST_WRITE) || (state_r == ST_DRAIN) || (state_r == ST_READ);
        rd_en_s    = (state_r == ST_READ) && !empty && (rd_issued_r < BURST);
        rd_seen_s  = dout_vd && (state_r != ST_IDLE);
        rd_take_s  = rd_seen_s && (rd_cnt_r < BURST);
        mismatch_s = rd_take_s && (data_out != exp_value_s);
        wd_fire_s  = active_s && !wr_en_r && !dout_vd && (wd_r == WD_LAST);

        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: state_next_s = start_ok_s ? ST_WAIT_INIT : state_r;
            ST_WAIT_INIT:     state_next_s = phy_init_done ? ST_WRITE : ST_WAIT_INIT;
            ST_WRITE:         state_next_s = (wr_cnt_r == BURST) ? ST_DRAIN : ST_WRITE;
            ST_DRAIN:         state_next_s = (drain_r == DRAIN_LAST) ? ST_READ : ST_DRAIN;
            ST_READ:          state_next_s = (rd_cnt_r == BURST) ? ST_DONE : ST_READ;
            default:          state_next_s = ST_IDLE;
        endcase

        if (wd_fire_s) begin
            state_next_s   = ST_DONE;
            timeout_next_s = 1'b1;
        end else if (start_ok_s) begin
            timeout_next_s = 1'b0;
        end else begin
            timeout_next_s = timeout_r;
        end

        wr_cnt_next_s    = start_ok_s ? CNT_ZERO : (wr_en_r ? wr_cnt_r + CNT_ONE : wr_cnt_r);
        rd_issued_next_s = start_ok_s ? CNT_ZERO : (rd_en_s ? rd_issued_r + CNT_ONE : rd_issued_r);
        rd_cnt_next_s    = start_ok_s ? CNT_ZERO : (rd_take_s ? rd_cnt_r + CNT_ONE : rd_cnt_r);
        // a word beyond the burst is an error by itself, compared or not
        err_bump_s       = (mismatch_s || (rd_seen_s && !rd_take_s)) && (err_cnt_r != CNT_MAX);
        err_cnt_next_s   = start_ok_s ? CNT_ZERO : (err_bump_s ? err_cnt_r + CNT_ONE : err_cnt_r);
        drain_next_s     = (state_r == ST_DRAIN) ? drain_r + 3'd1 : 3'd0;
        wd_next_s        = (!active_s || (state_next_s != state_r) || wr_en_r || dout_vd)
                           ? WD_ZERO : wd_r + WD_ONE;

        // counting the write in flight keeps the strobe from overshooting the burst
        wr_en_next_s = (state_r == ST_WRITE) && (state_next_s == ST_WRITE) && !full
                       && (wr_cnt_next_s < BURST);
        busy_next_s  = (state_next_s == ST_WAIT_INIT) || (state_next_s == ST_WRITE)
                       || (state_next_s == ST_DRAIN) || (state_next_s == ST_READ);
        done_next_s  = (state_next_s == ST_DONE);
        pass_next_s  = done_next_s && (err_cnt_next_s == CNT_ZERO)
                       && (rd_cnt_next_s == BURST) && !timeout_next_s;
    end

    // state and registered outputs
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            wr_cnt_r    <= CNT_ZERO;
            rd_cnt_r    <= CNT_ZERO;
            err_cnt_r   <= CNT_ZERO;
            rd_issued_r <= CNT_ZERO;
            wd_r        <= WD_ZERO;
            drain_r     <= 3'd0;
            wr_en_r     <= 1'b0;
            timeout_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            wr_cnt_r    <= wr_cnt_next_s;
            rd_cnt_r    <= rd_cnt_next_s;
            err_cnt_r   <= err_cnt_next_s;
            rd_issued_r <= rd_issued_next_s;
            wd_r        <= wd_next_s;
            drain_r     <= drain_next_s;
            wr_en_r     <= wr_en_next_s;
            timeout_r   <= timeout_next_s;
            busy_r      <= busy_next_s;
            done_r      <= done_next_s;
            pass_r      <= pass_next_s;
        end
    end

    fifo_tg_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_wr_gen (
        .clk(sys_clk), .rst(reset), .load(start_ok_s), .load_mode(mode),
        .advance(wr_en_r), .value(wr_value_s)
    );

    fifo_tg_pattern #(.DATA_W(DATA_W), .SEED(SEED)) u_exp_gen (
        .clk(sys_clk), .rst(reset), .load(start_ok_s), .load_mode(mode),
        .advance(rd_take_s), .value(exp_value_s)
    );

`ifdef FIFO_TG_ERR_CAPTURE_EN
    logic [CNT_W-1:0]  first_idx_r;
    logic [DATA_W-1:0] first_exp_r, first_act_r;
    logic              err_seen_r;

    // latch details of the first mismatch of a run
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            first_idx_r <= CNT_ZERO;
            first_exp_r <= {DATA_W{1'b0}};
            first_act_r <= {DATA_W{1'b0}};
            err_seen_r  <= 1'b0;
        end else if (start_ok_s) begin
            first_idx_r <= CNT_ZERO;
            first_exp_r <= {DATA_W{1'b0}};
            first_act_r <= {DATA_W{1'b0}};
            err_seen_r  <= 1'b0;
        end else if (mismatch_s && !err_seen_r) begin
            first_idx_r <= rd_cnt_r;
            first_exp_r <= exp_value_s;
            first_act_r <= data_out;
            err_seen_r  <= 1'b1;
        end else begin
            err_seen_r  <= err_seen_r;
        end
    end

    assign first_err_idx = first_idx_r;
    assign first_err_exp = first_exp_r;
    assign first_err_act = first_act_r;
    assign err_seen      = err_seen_r;
`endif

    assign wr_en   = wr_en_r;
    assign data_in = wr_en_r ? wr_value_s : {DATA_W{1'b0}};
    assign rd_en   = rd_en_s;
    assign busy    = busy_r;
    assign done    = done_r;
    assign pass    = pass_r;
    assign timeout = timeout_r;
    assign wr_cnt  = wr_cnt_r;
    assign rd_cnt  = rd_cnt_r;
    assign err_cnt = err_cnt_r;

endmodule

// File: tb/tb_fifo_traffic_gen.sv
// Scoreboard bench for fifo_traffic_gen with a behavioural FIFO responder:
// expected writes and run results are queued by stimulus and checked by a monitor.
module tb_fifo_traffic_gen;

    localparam int         DATA_W    = 8;
    localparam int         BURST_LEN = 16;
    localparam int         CNT_W     = 8;
    localparam int         TIMEOUT   = 64;
    localparam logic [7:0] SEED      = 8'hFE;

    logic             sys_clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       mode = 2'd0;
    logic             phy_init_done = 1'b0;
    logic             force_full = 1'b0;
    logic             mute = 1'b0;
    logic             full, empty, dout_vd;
    logic [7:0]       data_out;
    logic             wr_en, rd_en, busy, done, pass, timeout;
    logic [7:0]       data_in;
    logic [CNT_W-1:0] wr_cnt, rd_cnt, err_cnt;
`ifdef FIFO_TG_ERR_CAPTURE_EN
    logic [CNT_W-1:0] first_err_idx;
    logic [7:0]       first_err_exp, first_err_act;
    logic             err_seen;
`endif

    typedef struct {
        bit pass; bit tmo; int wr; int rd; int err;
        int cidx; int cexp; int cact; bit cseen;
    } status_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_wr_q[$];
    status_t    st_q[$];
    status_t    st_cur;
    logic [7:0] fifo_q[$];
    int         fifo_cnt = 0;
    int         rd_idx = 0;
    int         inject_idx = -1;
    logic       done_d = 1'b0;
    logic       full_d = 1'b0;

    fifo_traffic_gen #(
        .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .CNT_W(CNT_W), .SEED(SEED), .TIMEOUT(TIMEOUT)
    ) dut (
        .sys_clk(sys_clk), .reset(reset), .start(start), .mode(mode),
        .phy_init_done(phy_init_done), .full(full), .empty(empty), .dout_vd(dout_vd),
        .data_out(data_out), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
`ifdef FIFO_TG_ERR_CAPTURE_EN
        , .first_err_idx(first_err_idx), .first_err_exp(first_err_exp),
        .first_err_act(first_err_act), .err_seen(err_seen)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    assign full  = force_full;
    assign empty = (fifo_cnt == 0);

    task automatic chk(input string name, input longint unsigned act, input longint unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // FIFO responder: one-cycle read latency, optional bit flip, optional silence
    always @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            fifo_q.delete();
            fifo_cnt <= 0;
            dout_vd  <= 1'b0;
            data_out <= 8'h00;
            rd_idx   <= 0;
        end else begin
            if (rd_en && !mute && fifo_q.size() > 0) begin
                data_out <= fifo_q[0] ^ ((rd_idx == inject_idx) ? 8'h01 : 8'h00);
                dout_vd  <= 1'b1;
                rd_idx   <= rd_idx + 1;
                void'(fifo_q.pop_front());
            end else begin
                dout_vd <= 1'b0;
            end
            if (wr_en) fifo_q.push_back(data_in);
            fifo_cnt <= fifo_q.size();
            if (start) rd_idx <= 0;
        end
    end

    // monitor: write stream, back-pressure and end-of-run results
    always @(negedge sys_clk) begin
        if (!reset) begin
            if (wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL write_unexpected: data_in=%0h, expected no write", data_in);
                end else begin
                    chk("write_data", data_in, exp_wr_q.pop_front());
                end
            end
            if (full && full_d) chk("wr_en_while_full", wr_en, 1'b0);
            if (done && !done_d) begin
                if (st_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: done=1, expected no finished run");
                end else begin
                    st_cur = st_q.pop_front();
                    chk("pass", pass, st_cur.pass);
                    chk("timeout", timeout, st_cur.tmo);
                    chk("wr_cnt", wr_cnt, st_cur.wr);
                    chk("rd_cnt", rd_cnt, st_cur.rd);
                    chk("err_cnt", err_cnt, st_cur.err);
                    chk("busy_at_done", busy, 1'b0);
`ifdef FIFO_TG_ERR_CAPTURE_EN
                    chk("err_seen", err_seen, st_cur.cseen);
                    chk("first_err_idx", first_err_idx, st_cur.cidx);
                    chk("first_err_exp", first_err_exp, st_cur.cexp);
                    chk("first_err_act", first_err_act, st_cur.cact);
`endif
                end
            end
        end
        done_d <= done;
        full_d <= full;
    end

    function automatic logic [7:0] next_val(input logic [1:0] m, input logic [7:0] v);
        case (m)
            2'd0:    return v + 8'd1;
            2'd1:    return v[0] ? ((v >> 1) ^ 8'hB8) : (v >> 1);
            2'd2:    return {v[6:0], v[7]};
            default: return ~v;
        endcase
    endfunction

    task automatic push_writes(input logic [1:0] m);
        logic [7:0] v;
        v = (m == 2'd2) ? 8'h01 : SEED;
        for (int i = 0; i < BURST_LEN; i++) begin
            exp_wr_q.push_back(v);
            v = next_val(m, v);
        end
    endtask

    task automatic push_status(input bit p, input bit t, input int w, input int r, input int e,
                               input int ci, input int ce, input int ca, input bit cs);
        status_t s;
        s.pass = p; s.tmo = t; s.wr = w; s.rd = r; s.err = e;
        s.cidx = ci; s.cexp = ce; s.cact = ca; s.cseen = cs;
        st_q.push_back(s);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_start(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 2000 && !done; i++) @(negedge sys_clk);
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s: done never rose, expected completion within 2000 cycles", name);
        end
        tick(2);
    endtask

    task automatic wait_wr_cnt(input int n);
        for (int i = 0; i < 2000 && wr_cnt != n; i++) @(negedge sys_clk);
        chk("reach_wr_cnt", wr_cnt, n);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_wr_en"}, wr_en, 1'b0);
        chk({name, "_rd_en"}, rd_en, 1'b0);
        chk({name, "_busy"}, busy, 1'b0);
        chk({name, "_done"}, done, 1'b0);
        chk({name, "_pass"}, pass, 1'b0);
        chk({name, "_timeout"}, timeout, 1'b0);
        chk({name, "_wr_cnt"}, wr_cnt, 0);
        chk({name, "_rd_cnt"}, rd_cnt, 0);
        chk({name, "_err_cnt"}, err_cnt, 0);
        chk({name, "_data_in"}, data_in, 8'h00);
    endtask

    initial begin
        int k;
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;
        tick(2);

        // incrementing run from SEED FE wraps through 00; init arrives late
        push_writes(2'd0);
        push_status(1'b1, 1'b0, 16, 16, 0, 0, 0, 0, 1'b0);
        pulse_start(2'd0);
        chk("busy_after_start", busy, 1'b1);
        tick(50);
        chk("no_write_before_init", wr_cnt, 0);
        phy_init_done = 1'b1;
        wait_done("run_incr");

        // LFSR with a back-pressure window mid-write
        push_writes(2'd1);
        push_status(1'b1, 1'b0, 16, 16, 0, 0, 0, 0, 1'b0);
        pulse_start(2'd1);
        wait_wr_cnt(5);
        force_full = 1'b1;
        tick(10);
        force_full = 1'b0;
        wait_done("run_lfsr_full");

        // walking-one with a corrupted read word 5 (expected 20, returned 21)
        inject_idx = 5;
        push_writes(2'd2);
        push_status(1'b0, 1'b0, 16, 16, 1, 5, 8'h20, 8'h21, 1'b1);
        pulse_start(2'd2);
        wait_done("run_walk_flip");
        inject_idx = -1;

        // alternate pattern; a start during readback must be ignored
        push_writes(2'd3);
        push_status(1'b1, 1'b0, 16, 16, 0, 0, 0, 0, 1'b0);
        pulse_start(2'd3);
        for (int i = 0; i < 2000 && !dout_vd; i++) @(negedge sys_clk);
        chk("readback_seen", dout_vd, 1'b1);
        pulse_start(2'd0);
        chk("busy_after_ignored_start", busy, 1'b1);
        wait_done("run_alt");

        // FIFO never returns data: watchdog fires 64 cycles into READ
        mute = 1'b1;
        push_writes(2'd0);
        push_status(1'b0, 1'b1, 16, 0, 0, 0, 0, 0, 1'b0);
        pulse_start(2'd0);
        for (int i = 0; i < 2000 && !rd_en; i++) @(negedge sys_clk);
        chk("read_phase_reached", rd_en, 1'b1);
        k = 0;
        while (!done && k < 200) begin
            @(negedge sys_clk);
            k++;
        end
        chk("timeout_latency", k, 64);
        tick(2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        mute  = 1'b0;
        tick(2);

        // reset mid-write, then a clean run
        push_writes(2'd0);
        pulse_start(2'd0);
        wait_wr_cnt(7);
        #1 reset = 1'b1;
        #1 check_all_zero("reset_mid_run");
        exp_wr_q.delete();
        @(negedge sys_clk);
        reset = 1'b0;
        tick(2);
        push_writes(2'd0);
        push_status(1'b1, 1'b0, 16, 16, 0, 0, 0, 0, 1'b0);
        pulse_start(2'd0);
        wait_done("run_after_reset");

        chk("write_queue_drained", exp_wr_q.size(), 0);
        chk("status_queue_drained", st_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_traffic_gen.md
Name: fifo_traffic_gen

Overview:
Synthesizable traffic generator and checker for the DDR2-backed FIFO (sim_fifo_top class). It succeeds the fixed incrementing-counter stimulus: programmable data width, burst length, four data patterns and self-checking readback. It waits for phy_init_done, writes a burst under full back-pressure, reads it back and compares against a regenerated expected stream. It reports pass/fail, counters and a timeout. It sits beside the FIFO in bench and on-board test builds; both FIFO clocks are tied to sys_clk in this configuration.

Parameters:
DATA_W, 32, FIFO data width (8, 16, 32 or 64)
BURST_LEN, 1024, words written then read per run (>=1)
CNT_W, 16, width of wr_cnt/rd_cnt/err_cnt; must satisfy 2**CNT_W > BURST_LEN
SEED, 1, pattern start value (must be nonzero for LFSR mode)
TIMEOUT, 4096, idle cycles allowed in WRITE or READ without progress

Ports:
sys_clk  in  1  single clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; starts a run from IDLE or DONE, ignored otherwise
mode  in  2  pattern, sampled on start: 0 incr, 1 LFSR, 2 walking-one, 3 SEED/~SEED alternate
phy_init_done  in  1  DDR2 calibration complete
full  in  1  FIFO full
empty  in  1  FIFO empty
dout_vd  in  1  data_out valid this cycle
data_out  in  DATA_W  FIFO read data
wr_en  out  1  FIFO write strobe
data_in  out  DATA_W  FIFO write data
rd_en  out  1  FIFO read request
busy  out  1  run in progress
done  out  1  run finished (level, held until next start)
pass  out  1  valid when done: err_cnt==0, rd_cnt==BURST_LEN, no timeout
timeout  out  1  watchdog fired
wr_cnt, rd_cnt, err_cnt  out  CNT_W each  accepted writes, valid reads, mismatches (saturating)

Behaviour:
- Reset: all outputs 0. State IDLE. Generators reload SEED.
- FSM: IDLE -start-> WAIT_INIT (latch mode, clear counters/flags, reload both generators).
- WAIT_INIT -phy_init_done-> WRITE. No watchdog in WAIT_INIT.
- WRITE: wr_en = !full && wr_cnt<BURST_LEN, registered. data_in is the current write-generator value. On each cycle with wr_en=1: wr_cnt++ and generator advances. full is sampled the same cycle, so the FIFO must tolerate one write after full rises (almost_full margin is the FIFO's job).
- WRITE -> DRAIN when wr_cnt==BURST_LEN. DRAIN lasts 8 cycles, then READ.
- READ: rd_en = !empty && rd_issued<BURST_LEN. rd_issued is an internal CNT_W counter.
- On every dout_vd: if rd_cnt<BURST_LEN, compare data_out with the expected generator; on mismatch err_cnt++ (saturates at all-ones); rd_cnt++; expected generator advances. An extra dout_vd beyond BURST_LEN increments err_cnt only.
- READ -> DONE when rd_cnt==BURST_LEN.
- Watchdog: counter clears on any wr_en or dout_vd and on each state change. Reaching TIMEOUT in WRITE/DRAIN/READ sets timeout=1 and forces DONE.
- DONE: busy=0, done=1, pass computed there and held. A start from DONE behaves as from IDLE.
- busy=1 in WAIT_INIT through READ. A start while busy is ignored.
- Patterns advance per accepted word, all DATA_W wide:
  - incr: +1, wraps modulo 2**DATA_W.
  - LFSR: Galois, taps from the package per DATA_W. An all-zero state never occurs.
  - walking-one: rotate left 1; the first value is 1 regardless of SEED.
  - alternate: SEED, ~SEED, SEED...
- Reset mid-run: immediate return to IDLE, outputs 0. The FIFO is not flushed; a fresh run requires the FIFO to be reset too.

Optional Feature:
FIFO_TG_ERR_CAPTURE_EN: when defined, adds outputs first_err_idx (CNT_W), first_err_exp (DATA_W), first_err_act (DATA_W) and err_seen. The first mismatch of a run latches the rd_cnt value, expected word and actual word; these are held until the next start and cleared by reset. When undefined, these ports and their registers do not exist and behaviour is otherwise identical.

Decomposition:
- Package fifo_tg_pkg: mode encoding constants (MODE_INCR/LFSR/WALK/ALT), state enum, LFSR tap function for DATA_W 8/16/32/64, DRAIN_CYCLES=8.
- One sub-module, fifo_tg_pattern: holds one generator (load SEED, advance, mode). It is instantiated twice, once for write and once for expected.

Test Plan:
- Loopback, mode 0, BURST_LEN=16, SEED=1, phy_init_done high at cycle 50 -> data_in 1..16 written; done with pass=1, wr_cnt=rd_cnt=16, err_cnt=0.
- Mode 1 DATA_W=16 BURST_LEN=1024 with full forced high 100 cycles mid-write -> wr_en low while full; no lost or duplicated word; pass=1.
- Mode 2 DATA_W=8: inject a bit flip on read word 5 -> err_cnt=1, pass=0. With FIFO_TG_ERR_CAPTURE_EN: first_err_idx=5, first_err_exp=8'h20.
- FIFO never returns data (dout_vd stuck 0), TIMEOUT=64 -> timeout=1, done=1, pass=0, rd_cnt=0, 64 cycles after READ entry.
- Reset pulse at wr_cnt=7 -> all outputs 0 next edge. A new start (FIFO also reset) runs cleanly with pass=1.
- Mode 0 DATA_W=8 SEED=8'hFE BURST_LEN=4 -> data_in FE, FF, 00, 01 (wrap); pass=1. A start pulse during READ is ignored.
